// File: rtl/digi_cmp_defs.sv
// Shared definitions for the sequential digit-serial magnitude comparator.
// Holds the FSM encoding and the chunk-count / index-width helpers.
package digi_cmp_defs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Index counter needs at least one bit even for a single chunk
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/digi_cmp_chunk.sv
// Combinational CHUNK-bit unsigned comparator for one digit.
module digi_cmp_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    output logic             c_lt,
    output logic             c_eq,
    output logic             c_gt
);

    assign c_lt = (x < y);
    assign c_eq = (x == y);
    assign c_gt = (x > y);

endmodule

// File: rtl/digi_cmp_seq.sv
// Multi-cycle magnitude comparator: one CHUNK-bit digit per cycle, MSB first,
// stopping at the first differing digit. Signed mode uses offset-binary mapping.
module digi_cmp_seq
    import digi_cmp_defs::*;
#(
    parameter int WIDTH  = 16,
    parameter int CHUNK  = 4,
    parameter int NCHUNK = WIDTH / CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             gt,
    output logic             eq
);

    localparam int IW = idx_w(nchunk(WIDTH, CHUNK));

    generate
        if ((WIDTH < CHUNK) || (WIDTH % CHUNK != 0)) begin : g_bad_params
            $fatal(1, "digi_cmp_seq: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [IW-1:0]    idx;
    logic [31:0]      base;
    logic [WIDTH-1:0] flip;
    logic             last;
    logic             c_lt;
    logic             c_eq;
    logic             c_gt;

    assign base = 32'(idx) * 32'(CHUNK);
    assign last = (idx == '0);
    assign flip = signed_mode ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

    digi_cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
        .x    (a_r[base +: CHUNK]),
        .y    (b_r[base +: CHUNK]),
        .c_lt (c_lt),
        .c_eq (c_eq),
        .c_gt (c_gt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = CMP;
            CMP:     if (!c_eq || last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CMP);
        done = (state == DONE);
    end

    // Result flags hold through IDLE until the next accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r <= '0;
            b_r <= '0;
            idx <= '0;
            lt  <= 1'b0;
            gt  <= 1'b0;
            eq  <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                a_r <= a ^ flip;
                b_r <= b ^ flip;
                idx <= IW'(NCHUNK - 1);
                lt  <= 1'b0;
                gt  <= 1'b0;
                eq  <= 1'b0;
            end else if (state == CMP) begin
                if (c_lt) begin
                    lt <= 1'b1;
                end else if (c_gt) begin
                    gt <= 1'b1;
                end else if (last) begin
                    eq <= 1'b1;
                end else begin
                    idx <= idx - 1'b1;
                end
            end
        end
    end

endmodule
